// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the pipeline hazard and forwarding controller.
package hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } hfu_state_e;

  // Wide enough for the largest reload value, LOAD_STALL_CYCLES-1 = 2.
  localparam int unsigned BUBBLE_CNT_W = 2;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_bubble;
    logic ifid_flush;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard bus: pipeline side drives the stage info, the unit answers with controls.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 2,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 16
);

  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic                          id_jump;
  logic [REG_ADDR_W-1:0]         ex_rd;
  logic                          ex_reg_write;
  logic                          ex_mem_read;
  logic [REG_ADDR_W-1:0]         mem_rd;
  logic                          mem_reg_write;
  logic                          ex_branch_taken;
  logic                          wb_halt;

  logic [NUM_SRC*2-1:0]          fwd_sel;
  logic                          pc_stall;
  logic                          ifid_stall;
  logic                          idex_bubble;
  logic                          ifid_flush;
  logic                          halted;
  logic [CNT_W-1:0]              stall_count;
  logic [CNT_W-1:0]              flush_count;

  modport master (
    output id_rs, id_rs_used, id_jump, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_branch_taken, wb_halt,
    input  fwd_sel, pc_stall, ifid_stall, idex_bubble, ifid_flush, halted,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rs_used, id_jump, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, ex_branch_taken, wb_halt,
    output fwd_sel, pc_stall, ifid_stall, idex_bubble, ifid_flush, halted,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-source comparator: forwarding select and load-use hit for one ID operand.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 2
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_rs_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_reg_write,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  output fwd_sel_e              o_sel,
  output logic                  o_load_use
);

  logic w_ex_hit;
  logic w_mem_hit;

  // Register 0 is ordinary storage here, so no zero-index exclusion.
  assign w_ex_hit   = i_rs_used && i_ex_reg_write  && (i_rs == i_ex_rd);
  assign w_mem_hit  = i_rs_used && i_mem_reg_write && (i_rs == i_mem_rd);
  assign o_load_use = w_ex_hit && i_ex_mem_read;

  always_comb begin
    // NOTE: default first so every path assigns o_sel and no latch is inferred.
    o_sel = FWD_RF;
    if (w_ex_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller beside ID: registered forwarding selects, load-use
// bubbles, branch/jump flushes, HLT freeze and saturating statistics.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W        = 2,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_unit_if.slave bus
);

  localparam logic [BUBBLE_CNT_W-1:0] STALL_RELOAD = BUBBLE_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_ONE   = BUBBLE_CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ONE      = CNT_W'(1);

  logic [NUM_SRC-1:0][1:0]  w_sel;
  logic [NUM_SRC-1:0]       w_load_use_src;
  logic                     w_load_use;
  logic                     w_fwd_kill;
  logic                     w_stall_evt;
  ctrl_t                    w_ctrl;

  hfu_state_e               r_state;
  hfu_state_e               w_state_nxt;
  logic [BUBBLE_CNT_W-1:0]  r_bubble_cnt;
  logic [BUBBLE_CNT_W-1:0]  w_bubble_cnt_nxt;
  logic [NUM_SRC*2-1:0]     r_fwd_sel;
  logic [CNT_W-1:0]         r_stall_count;
  logic [CNT_W-1:0]         r_flush_count;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_forward_unit_fwd_select #(
      .REG_ADDR_W(REG_ADDR_W)
    ) u_fwd_select (
      .i_rs           (bus.id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .i_rs_used      (bus.id_rs_used[k]),
      .i_ex_rd        (bus.ex_rd),
      .i_ex_reg_write (bus.ex_reg_write),
      .i_ex_mem_read  (bus.ex_mem_read),
      .i_mem_rd       (bus.mem_rd),
      .i_mem_reg_write(bus.mem_reg_write),
      .o_sel          (w_sel[k]),
      .o_load_use     (w_load_use_src[k])
    );
  end

  assign w_load_use = |w_load_use_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_bubble_cnt <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      r_state      <= w_state_nxt;
      r_bubble_cnt <= w_bubble_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bubble_cnt_nxt = r_bubble_cnt;
    case (r_state)
      RUN: begin
        // The hazard cycle itself is the first bubble; STALL supplies the rest.
        if (!bus.ex_branch_taken && w_load_use && (LOAD_STALL_CYCLES > 1)) begin
          w_state_nxt      = STALL;
          w_bubble_cnt_nxt = STALL_RELOAD;
        end
      end
      STALL: begin
        if (bus.ex_branch_taken || (r_bubble_cnt <= BUBBLE_ONE)) begin
          w_state_nxt      = RUN;
          w_bubble_cnt_nxt = '0;
        end else begin
          w_bubble_cnt_nxt = r_bubble_cnt - BUBBLE_ONE;
        end
      end
      default: ;
    endcase
    if (bus.wb_halt) begin
      w_state_nxt      = HALTED;
      w_bubble_cnt_nxt = '0;
    end
  end

  always_comb begin
    w_ctrl      = '0;
    w_stall_evt = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.ex_branch_taken) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
        end else if (w_load_use) begin
          w_ctrl.pc_stall    = 1'b1;
          w_ctrl.ifid_stall  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
          w_stall_evt        = 1'b1;
        end else if (bus.id_jump) begin
          w_ctrl.ifid_flush  = 1'b1;
        end
      end
      STALL: begin
        if (bus.ex_branch_taken) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
        end else begin
          w_ctrl.pc_stall    = 1'b1;
          w_ctrl.ifid_stall  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
          w_stall_evt        = 1'b1;
        end
      end
      HALTED: begin
        w_ctrl.pc_stall    = 1'b1;
        w_ctrl.ifid_stall  = 1'b1;
        w_ctrl.idex_bubble = 1'b1;
        w_ctrl.halted      = 1'b1;
      end
      default: ;
    endcase
  end

  // A bubbled or flushed ID slot never reaches EX, so its select is dropped.
  assign w_fwd_kill = w_ctrl.idex_bubble | w_ctrl.ifid_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_sel <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        r_fwd_sel[k*2 +: 2] <= w_fwd_kill ? FWD_RF : w_sel[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_evt && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
      if (w_ctrl.ifid_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  assign bus.fwd_sel     = r_fwd_sel;
  assign bus.pc_stall    = w_ctrl.pc_stall;
  assign bus.ifid_stall  = w_ctrl.ifid_stall;
  assign bus.idex_bubble = w_ctrl.idex_bubble;
  assign bus.ifid_flush  = w_ctrl.ifid_flush;
  assign bus.halted      = w_ctrl.halted;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: three configurations (default, 2-cycle load stall, 2-bit counters).
module tb_hazard_forward_unit;

  typedef struct packed {
    logic [3:0] id_rs;
    logic [1:0] id_rs_used;
    logic       id_jump;
    logic [1:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [1:0] mem_rd;
    logic       mem_reg_write;
    logic       ex_branch_taken;
    logic       wb_halt;
  } stim_t;

  typedef struct packed {
    logic [3:0]  fwd;
    logic [15:0] sc;
    logic [15:0] fc;
  } post_t;

  typedef struct {
    stim_t      s;
    logic [4:0] ctl;   // {pc_stall, ifid_stall, idex_bubble, ifid_flush, halted}
    post_t      post;
  } row_t;

  logic       clk;
  logic       reset;
  stim_t      stim;
  logic [2:0] en;
  post_t      exp_q[$];
  int         n_checks;
  int         n_fail;

  hazard_forward_unit_if #(.REG_ADDR_W(2), .NUM_SRC(2), .CNT_W(16)) if_a ();
  hazard_forward_unit_if #(.REG_ADDR_W(2), .NUM_SRC(2), .CNT_W(16)) if_b ();
  hazard_forward_unit_if #(.REG_ADDR_W(2), .NUM_SRC(2), .CNT_W(2))  if_c ();

  assign {if_a.id_rs, if_a.id_rs_used, if_a.id_jump, if_a.ex_rd, if_a.ex_reg_write,
          if_a.ex_mem_read, if_a.mem_rd, if_a.mem_reg_write, if_a.ex_branch_taken,
          if_a.wb_halt} = en[0] ? stim : '0;
  assign {if_b.id_rs, if_b.id_rs_used, if_b.id_jump, if_b.ex_rd, if_b.ex_reg_write,
          if_b.ex_mem_read, if_b.mem_rd, if_b.mem_reg_write, if_b.ex_branch_taken,
          if_b.wb_halt} = en[1] ? stim : '0;
  assign {if_c.id_rs, if_c.id_rs_used, if_c.id_jump, if_c.ex_rd, if_c.ex_reg_write,
          if_c.ex_mem_read, if_c.mem_rd, if_c.mem_reg_write, if_c.ex_branch_taken,
          if_c.wb_halt} = en[2] ? stim : '0;

  hazard_forward_unit #(.REG_ADDR_W(2), .NUM_SRC(2), .LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  hazard_forward_unit #(.REG_ADDR_W(2), .NUM_SRC(2), .LOAD_STALL_CYCLES(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );
  hazard_forward_unit #(.REG_ADDR_W(2), .NUM_SRC(2), .LOAD_STALL_CYCLES(1), .CNT_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .bus(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] ctl_of(input int d);
    case (d)
      0:       return {if_a.pc_stall, if_a.ifid_stall, if_a.idex_bubble, if_a.ifid_flush, if_a.halted};
      1:       return {if_b.pc_stall, if_b.ifid_stall, if_b.idex_bubble, if_b.ifid_flush, if_b.halted};
      default: return {if_c.pc_stall, if_c.ifid_stall, if_c.idex_bubble, if_c.ifid_flush, if_c.halted};
    endcase
  endfunction

  function automatic post_t post_of(input int d);
    post_t p;
    case (d)
      0:       p = '{fwd: if_a.fwd_sel, sc: if_a.stall_count, fc: if_a.flush_count};
      1:       p = '{fwd: if_b.fwd_sel, sc: if_b.stall_count, fc: if_b.flush_count};
      default: p = '{fwd: if_c.fwd_sel, sc: 16'(if_c.stall_count), fc: 16'(if_c.flush_count)};
    endcase
    return p;
  endfunction

  function automatic stim_t mk(input logic [1:0] rs1, input logic [1:0] rs0,
                               input logic [1:0] used, input logic jump,
                               input logic [1:0] ex_rd, input logic ex_w, input logic ex_mr,
                               input logic [1:0] mem_rd, input logic mem_w,
                               input logic br, input logic halt);
    stim_t s;
    s.id_rs           = {rs1, rs0};
    s.id_rs_used      = used;
    s.id_jump         = jump;
    s.ex_rd           = ex_rd;
    s.ex_reg_write    = ex_w;
    s.ex_mem_read     = ex_mr;
    s.mem_rd          = mem_rd;
    s.mem_reg_write   = mem_w;
    s.ex_branch_taken = br;
    s.wb_halt         = halt;
    return s;
  endfunction

  function automatic row_t mkrow(input stim_t s, input logic [4:0] ctl, input logic [3:0] fwd,
                                 input logic [15:0] sc, input logic [15:0] fc);
    row_t r;
    r.s    = s;
    r.ctl  = ctl;
    r.post = '{fwd: fwd, sc: sc, fc: fc};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one ID cycle into DUT d and queues what must be visible after the edge.
  task automatic drive(input int d, input row_t r);
    stim = r.s;
    en   = 3'b001 << d;
    exp_q.push_back(r.post);
    #1;
  endtask

  task automatic do_reset();
    stim  = '0;
    en    = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim  = '0;
    en    = '0;
    reset = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (ctl_of(d) !== 5'b0) begin
        n_fail++;
        $display("FAIL reset ctl dut%0d got %b expected 00000", d, ctl_of(d));
      end
      n_checks++;
      if (post_of(d) !== post_t'(0)) begin
        n_fail++;
        $display("FAIL reset regs dut%0d got %h expected 0", d, post_of(d));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t  rows[$];
    post_t got, exp;
    do_reset();
    rows.push_back(mkrow(mk(2, 1, 2'b11, 0, 1, 1, 0, 0, 0, 0, 0), 5'b00000, 4'b0010, 0, 0));
    rows.push_back(mkrow(mk(2, 1, 2'b11, 0, 1, 1, 0, 2, 1, 0, 0), 5'b00000, 4'b0110, 0, 0));
    rows.push_back(mkrow(mk(1, 1, 2'b11, 0, 1, 1, 0, 1, 1, 0, 0), 5'b00000, 4'b1010, 0, 0));
    rows.push_back(mkrow(mk(1, 1, 2'b01, 0, 1, 1, 0, 1, 1, 0, 0), 5'b00000, 4'b0010, 0, 0));
    rows.push_back(mkrow(mk(0, 0, 2'b11, 0, 0, 1, 0, 3, 1, 0, 0), 5'b00000, 4'b1010, 0, 0));
    rows.push_back(mkrow(mk(3, 0, 2'b11, 0, 0, 0, 0, 3, 1, 0, 0), 5'b00000, 4'b0100, 0, 0));
    rows.push_back(mkrow(mk(3, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00000, 4'b0000, 0, 0));
    foreach (rows[i]) begin
      drive(0, rows[i]);
      n_checks++;
      if (ctl_of(0) !== rows[i].ctl) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] ctl got %b expected %b", i, ctl_of(0), rows[i].ctl);
      end
      tick();
      exp = exp_q.pop_front();
      got = post_of(0);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] fwd/stall/flush got %h/%0d/%0d expected %h/%0d/%0d",
                 i, got.fwd, got.sc, got.fc, exp.fwd, exp.sc, exp.fc);
      end
    end
  endtask

  task automatic test_load_use(input int d, input string tname, input row_t rows[$]);
    post_t got, exp;
    do_reset();
    foreach (rows[i]) begin
      drive(d, rows[i]);
      n_checks++;
      if (ctl_of(d) !== rows[i].ctl) begin
        n_fail++;
        $display("FAIL %s[%0d] ctl got %b expected %b", tname, i, ctl_of(d), rows[i].ctl);
      end
      tick();
      exp = exp_q.pop_front();
      got = post_of(d);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s[%0d] fwd/stall/flush got %h/%0d/%0d expected %h/%0d/%0d",
                 tname, i, got.fwd, got.sc, got.fc, exp.fwd, exp.sc, exp.fc);
      end
    end
  endtask

  task automatic test_halt();
    row_t  rows[$];
    post_t got, exp;
    do_reset();
    rows.push_back(mkrow(mk(0, 1, 2'b00, 0, 1, 1, 0, 0, 0, 0, 1), 5'b00000, 4'b0000, 0, 0));
    rows.push_back(mkrow(mk(0, 1, 2'b01, 0, 1, 1, 0, 0, 0, 1, 0), 5'b11101, 4'b0000, 0, 0));
    rows.push_back(mkrow(mk(0, 3, 2'b01, 1, 3, 1, 1, 0, 0, 0, 0), 5'b11101, 4'b0000, 0, 0));
    rows.push_back(mkrow(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11101, 4'b0000, 0, 0));
    foreach (rows[i]) begin
      drive(0, rows[i]);
      n_checks++;
      if (ctl_of(0) !== rows[i].ctl) begin
        n_fail++;
        $display("FAIL halt[%0d] ctl got %b expected %b", i, ctl_of(0), rows[i].ctl);
      end
      tick();
      exp = exp_q.pop_front();
      got = post_of(0);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL halt[%0d] fwd/stall/flush got %h/%0d/%0d expected %h/%0d/%0d",
                 i, got.fwd, got.sc, got.fc, exp.fwd, exp.sc, exp.fc);
      end
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl_of(0) !== 5'b00000) begin
      n_fail++;
      $display("FAIL halt_reset ctl got %b expected 00000", ctl_of(0));
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (ctl_of(0) !== 5'b00000) begin
      n_fail++;
      $display("FAIL halt_after_reset ctl got %b expected 00000", ctl_of(0));
    end
  endtask

  task automatic test_async_reset();
    post_t got, exp;
    do_reset();
    drive(0, mkrow(mk(0, 1, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0), 5'b00000, 4'b0010, 0, 0));
    tick();
    exp = exp_q.pop_front();
    got = post_of(0);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_pre fwd got %h expected %h", got.fwd, exp.fwd);
    end
    drive(1, mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 1, 0));
    tick();
    exp = exp_q.pop_front();
    got = post_of(1);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_stall_entry stall got %0d expected %0d", got.sc, exp.sc);
    end
    stim = '0;
    #1;
    n_checks++;
    if (ctl_of(1) !== 5'b11100) begin
      n_fail++;
      $display("FAIL async_in_stall ctl got %b expected 11100", ctl_of(1));
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl_of(1) !== 5'b00000 || post_of(1) !== post_t'(0) || post_of(0) !== post_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset got ctl %b regs %h/%h expected 00000 and 0", ctl_of(1),
               post_of(1), post_of(0));
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (ctl_of(1) !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_back_to_run ctl got %b expected 00000", ctl_of(1));
    end
  endtask

  initial begin
    row_t rows[$];
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_back_to_back();

    rows = {};
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 1, 0));
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 0, 0, 0, 3, 1, 0, 0), 5'b00000, 4'b0001, 1, 0));
    rows.push_back(mkrow(mk(2, 0, 2'b10, 0, 2, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 2, 0));
    rows.push_back(mkrow(mk(0, 2, 2'b01, 0, 2, 0, 1, 2, 1, 0, 0), 5'b00000, 4'b0001, 2, 0));
    test_load_use(0, "load_use_1", rows);

    rows = {};
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 1, 0));
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 0, 0, 0, 3, 1, 0, 0), 5'b11100, 4'b0000, 2, 0));
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00000, 4'b0000, 2, 0));
    rows.push_back(mkrow(mk(0, 3, 2'b00, 0, 3, 1, 1, 0, 0, 0, 0), 5'b00000, 4'b0000, 2, 0));
    test_load_use(1, "load_use_2", rows);

    rows = {};
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 1, 0), 5'b00110, 4'b0000, 0, 1));
    rows.push_back(mkrow(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00000, 4'b0000, 0, 1));
    test_load_use(0, "branch_vs_load", rows);

    rows = {};
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 1, 0));
    rows.push_back(mkrow(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0), 5'b00110, 4'b0000, 1, 1));
    rows.push_back(mkrow(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00000, 4'b0000, 1, 1));
    rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 2, 1));
    rows.push_back(mkrow(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11100, 4'b0000, 3, 1));
    rows.push_back(mkrow(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 5'b00000, 4'b0000, 3, 1));
    test_load_use(1, "branch_in_stall", rows);

    rows = {};
    rows.push_back(mkrow(mk(0, 1, 2'b01, 1, 1, 1, 0, 0, 0, 0, 0), 5'b00010, 4'b0000, 0, 1));
    rows.push_back(mkrow(mk(0, 1, 2'b01, 1, 1, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000, 1, 1));
    rows.push_back(mkrow(mk(0, 1, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0), 5'b00000, 4'b0010, 1, 1));
    test_load_use(0, "jump", rows);

    test_halt();
    test_async_reset();

    rows = {};
    for (int i = 0; i < 4; i++) begin
      rows.push_back(mkrow(mk(0, 3, 2'b01, 0, 3, 1, 1, 0, 0, 0, 0), 5'b11100, 4'b0000,
                           16'((i < 3) ? i + 1 : 3), 0));
    end
    for (int i = 0; i < 4; i++) begin
      rows.push_back(mkrow(mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0), 5'b00010, 4'b0000,
                           3, 16'((i < 3) ? i + 1 : 3)));
    end
    test_load_use(2, "saturation", rows);

    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
